// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - two-channel push-button synchronizer, debouncer and paddle move qualifier.
// Optional press auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WIDTH       = 18,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic left,
    input  logic right,
    output logic left_level,
    output logic right_level,
    output logic left_press,
    output logic right_press,
    output logic move_left,
    output logic move_right
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
            $error("button_conditioner: invalid parameters");
        end
    endgenerate

    // Channel 0 is left, channel 1 is right.
    logic [1:0]           sync_ff1;
    logic [1:0]           sync_ff2;
    state_t               state [2];
    logic [CNT_WIDTH-1:0] cnt   [2];
    logic [1:0]           level;
    logic [1:0]           press;
    logic [1:0]           cnt_done;
    logic [1:0]           level_nxt;
    logic                 move_left_q;
    logic                 move_right_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_WIDTH-1:0] RPT_FIRST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RPT_NEXT  = CNT_WIDTH'(REPEAT_PERIOD - 1);
    logic [CNT_WIDTH-1:0] rpt [2];
    logic [1:0]           rpt_started;
`endif

    // Level of the next cycle; the move outputs are registered from it so they align with level.
    always_comb begin
        cnt_done  = '0;
        level_nxt = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_done[i] = (cnt[i] == DB_LAST);
            case (state[i])
                PRESS_WAIT:   level_nxt[i] = sync_ff2[i] && cnt_done[i];
                HELD:         level_nxt[i] = 1'b1;
                RELEASE_WAIT: level_nxt[i] = sync_ff2[i] || !cnt_done[i];
                default:      level_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_ff1     <= '0;
            sync_ff2     <= '0;
            level        <= '0;
            press        <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                rpt[i]         <= '0;
                rpt_started[i] <= 1'b0;
`endif
            end
        end else begin
            sync_ff1     <= {right, left};
            sync_ff2     <= sync_ff1;
            level        <= level_nxt;
            move_left_q  <= level_nxt[0] & ~level_nxt[1];
            move_right_q <= level_nxt[1] & ~level_nxt[0];
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (sync_ff2[i]) begin
                            state[i] <= PRESS_WAIT;
                            cnt[i]   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync_ff2[i]) begin
                            state[i] <= IDLE;
                        end else if (cnt_done[i]) begin
                            state[i] <= HELD;
                            press[i] <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            rpt[i]         <= '0;
                            rpt_started[i] <= 1'b0;
`endif
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!sync_ff2[i]) begin
                            state[i] <= RELEASE_WAIT;
                            cnt[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
                            rpt[i]         <= '0;
                            rpt_started[i] <= 1'b0;
                        end else if (rpt[i] == (rpt_started[i] ? RPT_NEXT : RPT_FIRST)) begin
                            press[i]       <= 1'b1;
                            rpt[i]         <= '0;
                            rpt_started[i] <= 1'b1;
                        end else begin
                            rpt[i] <= rpt[i] + 1'b1;
`endif
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync_ff2[i]) begin
                            // A release bounce returns to HELD and restarts the repeat delay.
                            state[i] <= HELD;
`ifdef BTN_AUTOREPEAT_EN
                            rpt[i]         <= '0;
                            rpt_started[i] <= 1'b0;
`endif
                        end else if (cnt_done[i]) begin
                            state[i] <= IDLE;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    assign left_level  = level[0];
    assign right_level = level[1];
    assign left_press  = press[0];
    assign right_press = press[1];
    assign move_left   = move_left_q;
    assign move_right  = move_right_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic reset;
    logic left;
    logic right;
    logic left_level, right_level, left_press, right_press, move_left, move_right;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH      (4),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .left       (left),
        .right      (right),
        .left_level (left_level),
        .right_level(right_level),
        .left_press (left_press),
        .right_press(right_press),
        .move_left  (move_left),
        .move_right (move_right)
    );

    typedef struct {
        int cyc;
        bit val;
    } ev_t;

    ev_t        sbq [6][$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic [5:0] prev = '0;
    logic [5:0] outs;

    assign outs = {move_right, move_left, right_press, left_press, right_level, left_level};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string nm(int s);
        case (s)
            0: return "left_level";
            1: return "right_level";
            2: return "left_press";
            3: return "right_press";
            4: return "move_left";
            default: return "move_right";
        endcase
    endfunction

    function automatic void ev(int s, int c, bit v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        sbq[s].push_back(e);
    endfunction

    function automatic void pulse(int s, int c);
        ev(s, c, 1'b1);
        ev(s, c + 1, 1'b0);
    endfunction

    // Repeat pulses expected while HELD from edge entry until the edge that leaves HELD.
    function automatic void rep(int s, int entry, int leave);
        int c;
        c = entry + RD;
`ifndef BTN_AUTOREPEAT_EN
        c = leave;
`endif
        while (c < leave) begin
            pulse(s, c);
            c += RP;
        end
    endfunction

    // Monitor: every output transition must match the head of that signal's queue.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 6; s++) begin
                if (outs[s] !== prev[s]) begin
                    checks++;
                    if (sbq[s].size() == 0) begin
                        failures++;
                        $display("FAIL %s: unexpected change to %0b at cycle %0d", nm(s), outs[s], cyc);
                    end else begin
                        ev_t e;
                        e = sbq[s].pop_front();
                        if (e.cyc != cyc || e.val !== outs[s]) begin
                            failures++;
                            $display("FAIL %s: got %0b at cycle %0d, expected %0b at cycle %0d",
                                     nm(s), outs[s], cyc, e.val, e.cyc);
                        end
                    end
                end else if (sbq[s].size() > 0 && sbq[s][0].cyc < cyc) begin
                    ev_t e;
                    e = sbq[s].pop_front();
                    checks++;
                    failures++;
                    $display("FAIL %s: missed change to %0b due at cycle %0d (now %0d, value %0b)",
                             nm(s), e.val, e.cyc, cyc, outs[s]);
                end
            end
            prev = outs;
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_zero(string name);
        #1;
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL %s: outputs %b, expected 000000", name, outs);
        end
    endtask

    int b, c, d, r, s;

    initial begin
        reset = 1'b0;
        left  = 1'b1;
        right = 1'b1;
        step(5);
        check_zero("reset_state");
        prev   = outs;
        mon_en = 1'b1;

        // Qualify left out of reset, then release it.
        reset = 1'b1;
        right = 1'b0;
        b = cyc;
        pulse(2, b + 7);
        ev(0, b + 7, 1'b1); ev(4, b + 7, 1'b1);
        ev(0, b + 17, 1'b0); ev(4, b + 17, 1'b0);
        rep(2, b + 7, b + 13);
        step(10);
        left = 1'b0;
        step(12);

        // Three-cycle glitch is rejected.
        left = 1'b1;
        step(3);
        left = 1'b0;
        step(10);

        // Release bounce keeps level high; level falls 7 edges after the final low.
        left = 1'b1;
        b = cyc;
        c = b + 10;
        pulse(2, b + 7);
        ev(0, b + 7, 1'b1); ev(4, b + 7, 1'b1);
        ev(0, c + 10, 1'b0); ev(4, c + 10, 1'b0);
        rep(2, b + 7, c + 3);
        rep(2, c + 5, c + 6);
        step(10);
        left = 1'b0;
        step(2);
        left = 1'b1;
        step(1);
        left = 1'b0;
        step(12);

        // Conflict: both held masks both moves.
        left = 1'b1;
        b = cyc;
        d = b + 10;
        pulse(2, b + 7);
        ev(0, b + 7, 1'b1); ev(4, b + 7, 1'b1);
        rep(2, b + 7, b + 23);
        pulse(3, d + 7);
        ev(1, d + 7, 1'b1); ev(4, d + 7, 1'b0);
        ev(0, d + 17, 1'b0); ev(5, d + 17, 1'b1);
        rep(3, d + 7, d + 23);
        ev(1, d + 27, 1'b0); ev(5, d + 27, 1'b0);
        step(10);
        right = 1'b1;
        step(10);
        left = 1'b0;
        step(10);
        right = 1'b0;
        step(12);

        // Reset mid-wait and mid-HELD with right held throughout.
        right = 1'b1;
        step(4);
        reset = 1'b0;
        check_zero("reset_mid_wait");
        step(2);
        reset = 1'b1;
        r = cyc;
        pulse(3, r + 7);
        ev(1, r + 7, 1'b1); ev(5, r + 7, 1'b1);
        ev(1, r + 11, 1'b0); ev(5, r + 11, 1'b0);
        step(10);
        reset = 1'b0;
        check_zero("reset_mid_held");
        step(2);
        reset = 1'b1;
        s = cyc;
        pulse(3, s + 7);
        ev(1, s + 7, 1'b1); ev(5, s + 7, 1'b1);
        ev(1, s + 17, 1'b0); ev(5, s + 17, 1'b0);
        rep(3, s + 7, s + 13);
        step(10);
        right = 1'b0;
        step(12);

        // Long hold: single press, or repeats at 15, 18, ... when auto-repeat is built in.
        left = 1'b1;
        b = cyc;
        pulse(2, b + 7);
        ev(0, b + 7, 1'b1); ev(4, b + 7, 1'b1);
        ev(0, b + 32, 1'b0); ev(4, b + 32, 1'b0);
        rep(2, b + 7, b + 28);
        step(25);
        left = 1'b0;
        step(20);

        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sbq[i].size() != 0) begin
                failures++;
                $display("FAIL %s_drain: %0d events pending, expected 0", nm(i), sbq[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
